// File: rtl/mul_share_arb.sv
// Round-robin arbiter that time-shares one clocked multiplier among NR requesters,
// sequencing one multiply at a time with a watchdog against a silent multiplier.
module mul_share_arb #(
    parameter int NR     = 4,
    parameter int DW     = 64,
    parameter int TO_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [NR-1:0]          req_i,
    input  logic [NR-1:0][DW-1:0]  a_i,
    input  logic [NR-1:0][DW-1:0]  b_i,
    output logic [NR-1:0]          gnt_o,
    output logic [NR-1:0]          done_o,
    output logic [DW-1:0]          c_o,
    output logic                   busy_o,
    output logic                   err_o,
    output logic                   mul_en_o,
    output logic [DW-1:0]          mul_a_o,
    output logic [DW-1:0]          mul_b_o,
    input  logic                   mul_valid_i,
    input  logic [DW-1:0]          mul_c_i
);

    localparam int IW = (NR > 1) ? $clog2(NR) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    logic [IW-1:0] last;
    logic [IW-1:0] gidx;
    logic [7:0]    wd;

    logic [IW-1:0] pick;
    logic [IW-1:0] cand;
    logic          found;

    // Search starts just after the last served requester so that a
    // continuously requesting set is served in strict rotation.
    always_comb begin
        pick  = last;
        cand  = last;
        found = 1'b0;
        for (int i = 1; i <= NR; i++) begin
            cand = IW'((int'(last) + i) % NR);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            last     <= IW'(NR - 1);
            gidx     <= '0;
            wd       <= '0;
            gnt_o    <= '0;
            done_o   <= '0;
            c_o      <= '0;
            busy_o   <= 1'b0;
            err_o    <= 1'b0;
            mul_en_o <= 1'b0;
            mul_a_o  <= '0;
            mul_b_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        gidx     <= pick;
                        gnt_o    <= {{(NR-1){1'b0}}, 1'b1} << pick;
                        mul_a_o  <= a_i[pick];
                        mul_b_o  <= b_i[pick];
                        mul_en_o <= 1'b1;
                        busy_o   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    mul_en_o <= 1'b0;
                    wd       <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    // A result arriving on the last allowed cycle still wins.
                    if (mul_valid_i) begin
                        c_o    <= mul_c_i;
                        done_o <= gnt_o;
                        state  <= DONE;
                    end else if (wd == 8'(TO_CYC - 1)) begin
                        c_o    <= '0;
                        err_o  <= 1'b1;
                        done_o <= gnt_o;
                        state  <= DONE;
                    end else begin
                        wd <= wd + 8'd1;
                    end
                end
                DONE: begin
                    done_o <= '0;
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                    last   <= gidx;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arb.sv
// Randomized scoreboard bench for mul_share_arb with a behavioural multiplier
// of programmable latency and a round-robin reference model.
module tb_mul_share_arb;

    localparam int NR     = 4;
    localparam int DW     = 64;
    localparam int TO_CYC = 10;

    logic                  clk;
    logic                  rstn;
    logic [NR-1:0]         req_i;
    logic [NR-1:0][DW-1:0] a_i;
    logic [NR-1:0][DW-1:0] b_i;
    logic [NR-1:0]         gnt_o;
    logic [NR-1:0]         done_o;
    logic [DW-1:0]         c_o;
    logic                  busy_o;
    logic                  err_o;
    logic                  mul_en_o;
    logic [DW-1:0]         mul_a_o;
    logic [DW-1:0]         mul_b_o;
    logic                  mul_valid_i;
    logic [DW-1:0]         mul_c_i;

    mul_share_arb #(.NR(NR), .DW(DW), .TO_CYC(TO_CYC)) dut (
        .clk(clk), .rstn(rstn), .req_i(req_i), .a_i(a_i), .b_i(b_i),
        .gnt_o(gnt_o), .done_o(done_o), .c_o(c_o), .busy_o(busy_o), .err_o(err_o),
        .mul_en_o(mul_en_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_valid_i(mul_valid_i), .mul_c_i(mul_c_i)
    );

    typedef struct {
        int          idx;
        logic [63:0] c;
        bit          err;
        int          lat;
    } item_t;

    item_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          stray_cyc = -1;
    int          cur_lat = 3;
    int          m_last = NR - 1;
    logic [63:0] oa [NR][8];
    logic [63:0] ob [NR][8];
    int          nops_i [NR];
    int          opi [NR];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Multiplier: signed 20.44 x 20.44 product returned as 32.32.
    function automatic logic [63:0] prod(input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] pa, pb, p;
        pa = {{64{a[63]}}, a};
        pb = {{64{b[63]}}, b};
        p  = pa * pb;
        return p[119:56];
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Multiplier model; latency 0 means it never answers.
    initial begin
        int          mcnt;
        logic [63:0] mres;
        mcnt = 0;
        mres = '0;
        mul_valid_i = 1'b0;
        mul_c_i = '0;
        forever begin
            @(negedge clk);
            mul_valid_i = 1'b0;
            mul_c_i = {$urandom, $urandom};
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mul_valid_i = 1'b1;
                    mul_c_i = mres;
                end
            end
            if (cyc == stray_cyc) begin
                mul_valid_i = 1'b1;
                mul_c_i = 64'hDEAD;
            end
            if (mul_en_o && rstn) begin
                mcnt = cur_lat;
                mres = prod(mul_a_o, mul_b_o);
            end
        end
    end

    // Monitor / scoreboard
    initial begin
        item_t         it;
        logic [63:0]   m_c;
        bit            m_err;
        bit            prev_done;
        int            en_cyc;
        logic [NR-1:0] oh;
        m_c = '0;
        m_err = 0;
        prev_done = 0;
        en_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                q.delete();
                m_c = '0;
                m_err = 0;
                prev_done = 0;
                chk("rst_ctrl", 64'({gnt_o, done_o, busy_o, err_o, mul_en_o}), 64'd0);
                chk("rst_data", c_o | mul_a_o | mul_b_o, 64'd0);
                continue;
            end
            if (mul_en_o) en_cyc = cyc;
            if (prev_done) chk("idle_after_done", 64'({gnt_o, busy_o, done_o}), 64'd0);
            if (done_o != '0) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 64'(done_o), 64'd0);
                end else begin
                    it = q.pop_front();
                    oh = '0;
                    oh[it.idx] = 1'b1;
                    m_c = it.c;
                    if (it.err) m_err = 1;
                    chk("done_req", 64'(done_o), 64'(oh));
                    chk("gnt_req", 64'(gnt_o), 64'(oh));
                    chk("product", c_o, it.c);
                    chk("latency", 64'(cyc - en_cyc), 64'(it.lat));
                    chk("busy_in_done", 64'(busy_o), 64'd1);
                end
            end else begin
                chk("c_hold", c_o, m_c);
            end
            chk("err_flag", 64'(err_o), 64'(m_err));
            prev_done = (done_o != '0);
        end
    end

    // Requester behaviour: next operands or withdrawal on done; scramble captured operands.
    task automatic agent_step();
        for (int i = 0; i < NR; i++) begin
            if (done_o[i] && req_i[i]) begin
                opi[i]++;
                if (opi[i] >= nops_i[i]) begin
                    req_i[i] = 1'b0;
                end else begin
                    a_i[i] = oa[i][opi[i]];
                    b_i[i] = ob[i][opi[i]];
                end
            end else if (gnt_o[i] && !done_o[i]) begin
                a_i[i] = {$urandom, $urandom};
                b_i[i] = {$urandom, $urandom};
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("async_rst_ctrl", 64'({gnt_o, done_o, busy_o, err_o, mul_en_o}), 64'd0);
        chk("async_rst_data", c_o | mul_a_o | mul_b_o, 64'd0);
        req_i = '0;
        m_last = NR - 1;
        @(negedge clk);
        #2 rstn = 1'b1;
    endtask

    task automatic run_scenario(input logic [NR-1:0] set, input int nops, input int lat,
                                input bit preset);
        int  rem [NR];
        int  cnt [NR];
        int  total;
        int  j;
        int  n;
        bit  tmo;
        item_t it;
        cur_lat = lat;
        tmo = (lat == 0) || (lat > TO_CYC);
        total = 0;
        for (int i = 0; i < NR; i++) begin
            rem[i] = set[i] ? nops : 0;
            cnt[i] = 0;
            nops_i[i] = rem[i];
            opi[i] = 0;
            total += rem[i];
            if (!preset) begin
                for (int k = 0; k < nops; k++) begin
                    oa[i][k] = {$urandom, $urandom};
                    ob[i][k] = {$urandom, $urandom};
                end
            end
        end
        // Reference: strict rotation over requesters that still have work.
        for (int t = 0; t < total; t++) begin
            j = m_last;
            for (int k = 1; k <= NR; k++) begin
                if (rem[(m_last + k) % NR] > 0) begin
                    j = (m_last + k) % NR;
                    break;
                end
            end
            it.idx = j;
            it.err = tmo;
            it.c   = tmo ? 64'd0 : prod(oa[j][cnt[j]], ob[j][cnt[j]]);
            it.lat = tmo ? TO_CYC + 1 : lat + 1;
            q.push_back(it);
            rem[j]--;
            cnt[j]++;
            m_last = j;
        end
        @(negedge clk);
        for (int i = 0; i < NR; i++) begin
            if (set[i]) begin
                a_i[i] = oa[i][0];
                b_i[i] = ob[i][0];
            end
        end
        req_i = set;
        n = 0;
        while ((q.size() > 0 || req_i != '0) && n < total * (TO_CYC + 8) + 20) begin
            @(negedge clk);
            agent_step();
            n++;
        end
        if (q.size() > 0 || req_i != '0) begin
            chk("scenario_timeout", 64'(q.size()), 64'd0);
            do_reset();
        end
    endtask

    initial begin
        int n;
        rstn = 1'b0;
        req_i = '0;
        a_i = '0;
        b_i = '0;
        repeat (3) @(negedge clk);
        #2 rstn = 1'b1;

        oa[0][0] = 64'h0000_1000_0000_0000;
        ob[0][0] = 64'h0000_2000_0000_0000;
        run_scenario(4'b0001, 1, 3, 1);
        chk("single_c", c_o, 64'h0000_0002_0000_0000);
        chk("single_err", 64'(err_o), 64'd0);

        do_reset();
        run_scenario(4'b1111, 1, $urandom_range(1, TO_CYC), 0);
        run_scenario(4'b0101, 3, 2, 0);
        run_scenario(4'b0011, 2, 4, 0);
        run_scenario(4'b1011, 2, 1, 0);
        run_scenario(4'b0010, 1, TO_CYC, 0);
        repeat (12) begin
            run_scenario(NR'($urandom_range(1, (1 << NR) - 1)), $urandom_range(1, 3),
                         $urandom_range(1, TO_CYC), 0);
        end

        stray_cyc = cyc + 2;
        repeat (5) @(negedge clk);
        chk("stray_busy", 64'(busy_o), 64'd0);

        run_scenario(4'b0001, 1, 0, 0);
        chk("timeout_err", 64'(err_o), 64'd1);
        run_scenario(4'b1000, 1, TO_CYC + 1, 0);
        repeat (4) begin
            run_scenario(NR'($urandom_range(1, (1 << NR) - 1)), $urandom_range(1, 2),
                         $urandom_range(1, TO_CYC), 0);
        end

        cur_lat = 8;
        a_i[2] = {$urandom, $urandom};
        b_i[2] = {$urandom, $urandom};
        @(negedge clk);
        req_i = 4'b0100;
        n = 0;
        while (!mul_en_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("midop_en", 64'(mul_en_o), 64'd1);
        repeat (2) @(negedge clk);
        do_reset();
        repeat (12) @(negedge clk);
        chk("post_rst_c", c_o, 64'd0);
        run_scenario(4'b1111, 1, 5, 0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
